// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
//
// Machine-mode CSR file for the RV32I pipeline. Execute reads any CSR
// combinationally; writeback commits CSR writes, trap entry and mret. The
// block also runs the 64-bit mcycle/minstret counters, samples the three
// interrupt lines into mip and raises an interrupt request for the front end.
//
// Parameters
//   MTVEC_RESET  reset value of mtvec (low two bits forced to 00)
//   HART_ID      value returned by mhartid
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   readAddress/readData      combinational CSR read port
//   readIllegal               readAddress is not an implemented CSR
//   writeEnable/Address/Data  CSR write commit from writeback
//   retire                    one instruction retired this cycle
//   trapEnter/Cause/PC/Value  trap entry request and its mcause/mepc/mtval
//   mretCommit                mret retiring this cycle
//   external/timer/softwareInterrupt  level interrupt lines
//   trapVector                redirect target for trap entry
//   returnPC                  current mepc
//   interruptRequest/Cause    enabled pending interrupt and its mcause
//
// Configuration macro
//   CSR_VECTORED_EN  stores mtvec.MODE and vectors interrupts to
//                    base + 4*cause; without it every trap goes to base.
// ---------------------------------------------------------------------------
module csr_file #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] readAddress,
   output logic [31:0] readData,
   output logic        readIllegal,
   input  logic        writeEnable,
   input  logic [11:0] writeAddress,
   input  logic [31:0] writeData,
   input  logic        retire,
   input  logic        trapEnter,
   input  logic [31:0] trapCause,
   input  logic [31:0] trapPC,
   input  logic [31:0] trapValue,
   input  logic        mretCommit,
   input  logic        externalInterrupt,
   input  logic        timerInterrupt,
   input  logic        softwareInterrupt,
   output logic [31:0] trapVector,
   output logic [31:0] returnPC,
   output logic        interruptRequest,
   output logic [31:0] interruptCause
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MISA     = 12'h301;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

   localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
   localparam logic [31:0] INT_BITS_MASK = 32'h0000_0888;
   localparam logic [31:0] PC_MASK       = 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_EN
   localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFD;
`else
   localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFC;
`endif

   logic        mstatusMie,  mstatusMieNext;
   logic        mstatusMpie, mstatusMpieNext;
   logic [31:0] mieReg,      mieNext;
   logic [31:0] mtvecReg,    mtvecNext;
   logic [31:0] mscratchReg, mscratchNext;
   logic [31:0] mepcReg,     mepcNext;
   logic [31:0] mcauseReg,   mcauseNext;
   logic [31:0] mtvalReg,    mtvalNext;
   logic [31:0] mipReg,      mipNext;
   logic [63:0] mcycleReg,   mcycleNext;
   logic [63:0] minstretReg, minstretNext;

   logic [31:0] mstatusView;
   logic [31:0] pendingEnabled;

   // mstatus as software sees it: MPP hard-wired to machine mode, MPIE and
   // MIE are the only stored bits.
   assign mstatusView = {19'b0, 2'b11, 3'b0, mstatusMpie, 3'b0, mstatusMie, 3'b0};

   // Next-state computation. Updates are layered lowest priority first so
   // that mret overrides a CSR write to mstatus, and trap entry overrides
   // both mret and any write to mstatus/mepc/mcause/mtval. Writes to the
   // other CSRs are untouched by trap or mret and always commit. A counter
   // write replaces the increment for that cycle on both halves.
   always_comb begin
      mstatusMieNext  = mstatusMie;
      mstatusMpieNext = mstatusMpie;
      mieNext         = mieReg;
      mtvecNext       = mtvecReg;
      mscratchNext    = mscratchReg;
      mepcNext        = mepcReg;
      mcauseNext      = mcauseReg;
      mtvalNext       = mtvalReg;
      mipNext         = {20'b0, externalInterrupt, 3'b0, timerInterrupt, 3'b0,
                         softwareInterrupt, 3'b0};
      mcycleNext      = mcycleReg + 64'd1;
      minstretNext    = retire ? (minstretReg + 64'd1) : minstretReg;

      if (writeEnable) begin
         case (writeAddress)
            ADDR_MSTATUS: begin
               mstatusMieNext  = writeData[3];
               mstatusMpieNext = writeData[7];
            end
            ADDR_MIE:       mieNext      = writeData & INT_BITS_MASK;
            ADDR_MTVEC:     mtvecNext    = writeData & MTVEC_MASK;
            ADDR_MSCRATCH:  mscratchNext = writeData;
            ADDR_MEPC:      mepcNext     = writeData & PC_MASK;
            ADDR_MCAUSE:    mcauseNext   = writeData;
            ADDR_MTVAL:     mtvalNext    = writeData;
            ADDR_MCYCLE:    mcycleNext   = {mcycleReg[63:32], writeData};
            ADDR_MCYCLEH:   mcycleNext   = {writeData, mcycleReg[31:0]};
            ADDR_MINSTRET:  minstretNext = {minstretReg[63:32], writeData};
            ADDR_MINSTRETH: minstretNext = {writeData, minstretReg[31:0]};
            default: ;
         endcase
      end

      if (mretCommit) begin
         mstatusMieNext  = mstatusMpie;
         mstatusMpieNext = 1'b1;
      end

      if (trapEnter) begin
         mstatusMpieNext = mstatusMie;
         mstatusMieNext  = 1'b0;
         mepcNext        = trapPC & PC_MASK;
         mcauseNext      = trapCause;
         mtvalNext       = trapValue;
      end
   end

   // State registers. Reset clears everything at once, including both
   // counter halves, so no update in flight survives it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mstatusMie  <= 1'b0;
         mstatusMpie <= 1'b0;
         mieReg      <= 32'h0;
         mtvecReg    <= MTVEC_RESET & 32'hFFFF_FFFC;
         mscratchReg <= 32'h0;
         mepcReg     <= 32'h0;
         mcauseReg   <= 32'h0;
         mtvalReg    <= 32'h0;
         mipReg      <= 32'h0;
         mcycleReg   <= 64'h0;
         minstretReg <= 64'h0;
      end else begin
         mstatusMie  <= mstatusMieNext;
         mstatusMpie <= mstatusMpieNext;
         mieReg      <= mieNext;
         mtvecReg    <= mtvecNext;
         mscratchReg <= mscratchNext;
         mepcReg     <= mepcNext;
         mcauseReg   <= mcauseNext;
         mtvalReg    <= mtvalNext;
         mipReg      <= mipNext;
         mcycleReg   <= mcycleNext;
         minstretReg <= minstretNext;
      end
   end

   // Read port: purely from registered state, so a write only becomes
   // visible the cycle after it commits. Unknown addresses read zero and
   // flag readIllegal.
   always_comb begin
      readData    = 32'h0;
      readIllegal = 1'b0;
      case (readAddress)
         ADDR_MSTATUS:   readData = mstatusView;
         ADDR_MISA:      readData = MISA_VALUE;
         ADDR_MIE:       readData = mieReg;
         ADDR_MTVEC:     readData = mtvecReg;
         ADDR_MSCRATCH:  readData = mscratchReg;
         ADDR_MEPC:      readData = mepcReg;
         ADDR_MCAUSE:    readData = mcauseReg;
         ADDR_MTVAL:     readData = mtvalReg;
         ADDR_MIP:       readData = mipReg;
         ADDR_MCYCLE:    readData = mcycleReg[31:0];
         ADDR_MCYCLEH:   readData = mcycleReg[63:32];
         ADDR_MINSTRET:  readData = minstretReg[31:0];
         ADDR_MINSTRETH: readData = minstretReg[63:32];
         ADDR_MHARTID:   readData = HART_ID;
         default:        readIllegal = 1'b1;
      endcase
   end

   // Interrupt arbitration: external beats software beats timer. The cause
   // is reported whenever an enabled interrupt is pending; the request
   // itself is additionally gated by the global MIE bit.
   assign pendingEnabled = mipReg & mieReg;

   always_comb begin
      interruptCause = 32'h0;
      if (pendingEnabled[11]) begin
         interruptCause = 32'h8000_000B;
      end else if (pendingEnabled[3]) begin
         interruptCause = 32'h8000_0003;
      end else if (pendingEnabled[7]) begin
         interruptCause = 32'h8000_0007;
      end
      interruptRequest = mstatusMie & (|pendingEnabled);
   end

   // Trap redirect target. In vectored mode only interrupts (cause MSB set)
   // are spread across the table; exceptions always land on the base.
   always_comb begin
      trapVector = {mtvecReg[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
      if (mtvecReg[0] && trapCause[31]) begin
         trapVector = {mtvecReg[31:2], 2'b00} + {trapCause[29:0], 2'b00};
      end
`endif
   end

   assign returnPC = mepcReg;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
//
// Directed testbench for csr_file. Each step drives inputs, lets one rising
// edge pass, then samples one time unit later and compares against values
// worked out by hand.
// ---------------------------------------------------------------------------
module tb_csr_file;

   logic        clock;
   logic        reset;
   logic [11:0] readAddress;
   logic [31:0] readData;
   logic        readIllegal;
   logic        writeEnable;
   logic [11:0] writeAddress;
   logic [31:0] writeData;
   logic        retire;
   logic        trapEnter;
   logic [31:0] trapCause;
   logic [31:0] trapPC;
   logic [31:0] trapValue;
   logic        mretCommit;
   logic        externalInterrupt;
   logic        timerInterrupt;
   logic        softwareInterrupt;
   logic [31:0] trapVector;
   logic [31:0] returnPC;
   logic        interruptRequest;
   logic [31:0] interruptCause;

   int testsRun;
   int failCount;

   csr_file dut (
      .clock             (clock),
      .reset             (reset),
      .readAddress       (readAddress),
      .readData          (readData),
      .readIllegal       (readIllegal),
      .writeEnable       (writeEnable),
      .writeAddress      (writeAddress),
      .writeData         (writeData),
      .retire            (retire),
      .trapEnter         (trapEnter),
      .trapCause         (trapCause),
      .trapPC            (trapPC),
      .trapValue         (trapValue),
      .mretCommit        (mretCommit),
      .externalInterrupt (externalInterrupt),
      .timerInterrupt    (timerInterrupt),
      .softwareInterrupt (softwareInterrupt),
      .trapVector        (trapVector),
      .returnPC          (returnPC),
      .interruptRequest  (interruptRequest),
      .interruptCause    (interruptCause)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present a CSR write (or none), let one rising edge pass and settle.
   task automatic applyStimulus(input logic we, input logic [11:0] addr,
                                input logic [31:0] data);
      writeEnable  = we;
      writeAddress = addr;
      writeData    = data;
      @(posedge clock);
      #1;
      writeEnable  = 1'b0;
   endtask

   // Point the read port at a CSR and check what comes back.
   task automatic readCheck(input string tag, input logic [11:0] addr,
                            input logic [31:0] expected);
      readAddress = addr;
      #1;
      checkOutput(tag, readData, expected);
   endtask

   // Main directed sequence.
   initial begin
      testsRun          = 0;
      failCount         = 0;
      reset             = 1'b1;
      readAddress       = 12'h300;
      writeEnable       = 1'b0;
      writeAddress      = 12'h0;
      writeData         = 32'h0;
      retire            = 1'b0;
      trapEnter         = 1'b0;
      trapCause         = 32'h0;
      trapPC            = 32'h0;
      trapValue         = 32'h0;
      mretCommit        = 1'b0;
      externalInterrupt = 1'b0;
      timerInterrupt    = 1'b0;
      softwareInterrupt = 1'b0;

      // Values while reset is held
      #1;
      readCheck("rst_mstatus", 12'h300, 32'h0000_1800);
      readCheck("rst_mtvec",   12'h305, 32'h0000_0100);
      readCheck("rst_mhartid", 12'hF14, 32'h0000_0000);
      readCheck("rst_mcycle",  12'hB00, 32'h0000_0000);
      checkOutput("rst_irq",    {31'b0, interruptRequest}, 32'h0);
      checkOutput("rst_cause",  interruptCause, 32'h0);
      checkOutput("rst_vector", trapVector, 32'h0000_0100);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Unimplemented and read-only addresses
      readCheck("unimpl_data", 12'h7C0, 32'h0);
      checkOutput("unimpl_illegal", {31'b0, readIllegal}, 32'h1);
      applyStimulus(1'b1, 12'h301, 32'h0);
      readCheck("misa_ro", 12'h301, 32'h4000_0100);
      checkOutput("misa_legal", {31'b0, readIllegal}, 32'h0);

      // mepc write: old value in the same cycle, masked value afterwards
      writeEnable  = 1'b1;
      writeAddress = 12'h341;
      writeData    = 32'h0000_1237;
      readCheck("mepc_same_cycle", 12'h341, 32'h0);
      @(posedge clock);
      #1;
      writeEnable = 1'b0;
      readCheck("mepc_next_cycle", 12'h341, 32'h0000_1234);

      // mie keeps only bits 3/7/11
      applyStimulus(1'b1, 12'h304, 32'hFFFF_FFFF);
      readCheck("mie_mask", 12'h304, 32'h0000_0888);

      // Timer interrupt through to trap entry and mret
      applyStimulus(1'b1, 12'h304, 32'h0000_0080);
      applyStimulus(1'b1, 12'h300, 32'h0000_0008);
      readCheck("mstatus_mie", 12'h300, 32'h0000_1808);
      timerInterrupt = 1'b1;
      #1;
      checkOutput("irq_latency", {31'b0, interruptRequest}, 32'h0);
      applyStimulus(1'b0, 12'h0, 32'h0);
      checkOutput("irq_timer",   {31'b0, interruptRequest}, 32'h1);
      checkOutput("cause_timer", interruptCause, 32'h8000_0007);

      trapEnter = 1'b1;
      trapCause = 32'h8000_0007;
      trapPC    = 32'h0000_0080;
      trapValue = 32'h0;
      applyStimulus(1'b0, 12'h0, 32'h0);
      trapEnter = 1'b0;
      readCheck("trap_mstatus", 12'h300, 32'h0000_1880);
      readCheck("trap_mcause",  12'h342, 32'h8000_0007);
      checkOutput("trap_mepc", returnPC, 32'h0000_0080);
      checkOutput("trap_irq",  {31'b0, interruptRequest}, 32'h0);

      mretCommit = 1'b1;
      applyStimulus(1'b0, 12'h0, 32'h0);
      mretCommit = 1'b0;
      readCheck("mret_mstatus", 12'h300, 32'h0000_1888);
      checkOutput("mret_irq", {31'b0, interruptRequest}, 32'h1);

      // Priority among interrupts and read-only mip
      externalInterrupt = 1'b1;
      softwareInterrupt = 1'b1;
      applyStimulus(1'b1, 12'h304, 32'h0000_0888);
      checkOutput("cause_ext", interruptCause, 32'h8000_000B);
      applyStimulus(1'b1, 12'h344, 32'h0);
      readCheck("mip_ro", 12'h344, 32'h0000_0888);
      externalInterrupt = 1'b0;
      applyStimulus(1'b0, 12'h0, 32'h0);
      checkOutput("cause_sw", interruptCause, 32'h8000_0003);
      softwareInterrupt = 1'b0;
      applyStimulus(1'b0, 12'h0, 32'h0);
      checkOutput("cause_tmr", interruptCause, 32'h8000_0007);
      timerInterrupt = 1'b0;
      applyStimulus(1'b0, 12'h0, 32'h0);
      checkOutput("irq_none",   {31'b0, interruptRequest}, 32'h0);
      checkOutput("cause_none", interruptCause, 32'h0);

      // Trap entry wins over a same-cycle mcause write
      trapEnter = 1'b1;
      trapCause = 32'h0000_0002;
      trapPC    = 32'h0000_0103;
      trapValue = 32'h0000_DEAD;
      applyStimulus(1'b1, 12'h342, 32'h0000_0055);
      trapEnter = 1'b0;
      trapCause = 32'h0;
      readCheck("prio_mcause",  12'h342, 32'h0000_0002);
      readCheck("prio_mtval",   12'h343, 32'h0000_DEAD);
      readCheck("prio_mstatus", 12'h300, 32'h0000_1880);
      checkOutput("prio_mepc", returnPC, 32'h0000_0100);

      // mret wins over a same-cycle mstatus write
      mretCommit = 1'b1;
      applyStimulus(1'b1, 12'h300, 32'h0);
      mretCommit = 1'b0;
      readCheck("mret_over_write", 12'h300, 32'h0000_1888);

      // mcycle carry from low to high half
      applyStimulus(1'b1, 12'hB80, 32'h0000_0005);
      applyStimulus(1'b1, 12'hB00, 32'hFFFF_FFFE);
      readCheck("mcycle_preload",  12'hB00, 32'hFFFF_FFFE);
      readCheck("mcycleh_preload", 12'hB80, 32'h0000_0005);
      applyStimulus(1'b0, 12'h0, 32'h0);
      applyStimulus(1'b0, 12'h0, 32'h0);
      readCheck("mcycle_wrap",  12'hB00, 32'h0);
      readCheck("mcycleh_wrap", 12'hB80, 32'h0000_0006);

      // minstret: write beats retire, then counts and carries
      readCheck("minstret_idle", 12'hB02, 32'h0);
      retire = 1'b1;
      applyStimulus(1'b1, 12'hB02, 32'h0000_1000);
      readCheck("minstret_write", 12'hB02, 32'h0000_1000);
      applyStimulus(1'b0, 12'h0, 32'h0);
      readCheck("minstret_incr", 12'hB02, 32'h0000_1001);
      applyStimulus(1'b1, 12'hB02, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 12'h0, 32'h0);
      retire = 1'b0;
      readCheck("minstret_wrap",  12'hB02, 32'h0);
      readCheck("minstreth_wrap", 12'hB82, 32'h0000_0001);

      // Trap vector with mtvec = 0x201
      applyStimulus(1'b1, 12'h305, 32'h0000_0201);
`ifdef CSR_VECTORED_EN
      readCheck("mtvec_mode", 12'h305, 32'h0000_0201);
      trapCause = 32'h8000_000B;
      #1;
      checkOutput("vector_irq", trapVector, 32'h0000_022C);
      trapCause = 32'h0000_0002;
      #1;
      checkOutput("vector_exc", trapVector, 32'h0000_0200);
`else
      readCheck("mtvec_nomode", 12'h305, 32'h0000_0200);
      trapCause = 32'h8000_000B;
      #1;
      checkOutput("vector_irq", trapVector, 32'h0000_0200);
`endif
      trapCause = 32'h0;

      // Reset mid-operation drops the pending write and clears counters
      @(posedge clock);
      #1;
      writeEnable  = 1'b1;
      writeAddress = 12'h341;
      writeData    = 32'h0000_4444;
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midrst_mepc",   returnPC, 32'h0);
      checkOutput("midrst_vector", trapVector, 32'h0000_0100);
      readCheck("midrst_mstatus",   12'h300, 32'h0000_1800);
      readCheck("midrst_minstreth", 12'hB82, 32'h0);
      readCheck("midrst_mcycleh",   12'hB80, 32'h0);
      writeEnable = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 12'h0, 32'h0);
      checkOutput("postrst_mepc", returnPC, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
